// File: rtl/seq_recognizer_param.sv
// Runtime-programmable serial pattern recognizer with Mealy match flag and saturating match counter.
// Counter is built only when SEQ_RECOGNIZER_MATCH_COUNT_EN is defined; otherwise match_count is tied to 0.
module seq_recognizer_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = '0,
    parameter int               CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap,
    input  logic             valid,
    input  logic             x,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    // fill view | meaning
    // EMPTY     | fill == 0, no history accepted since reset/load/flush
    // FILLING   | 0 < fill < PAT_W-1, history partially valid
    // ARMED     | fill == PAT_W-1, the next valid bit can complete a match
    localparam int               FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_reg, pat_nxt;
    logic [PAT_W-2:0]  hist, hist_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [PAT_W-1:0]  window;
    logic              armed;
    logic              hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_reg <= PAT_RST;
            hist    <= '0;
            fill    <= '0;
        end else begin
            pat_reg <= pat_nxt;
            hist    <= hist_nxt;
            fill    <= fill_nxt;
        end
    end

    always_comb begin
        window   = {hist, x};
        armed    = (fill == FILL_MAX);
        hit      = valid & ~load & armed & (window == pat_reg);
        pat_nxt  = pat_reg;
        hist_nxt = hist;
        fill_nxt = fill;
        if (load) begin
            pat_nxt  = pattern_in;
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (valid) begin
            // A non-overlapping hit discards its bits so the next match needs a full fresh window.
            if (hit && !overlap) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                hist_nxt = window[PAT_W-2:0];
                fill_nxt = armed ? fill : fill + 1'b1;
            end
        end
    end

    assign z = hit;

`ifdef SEQ_RECOGNIZER_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (hit && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_recognizer_param.sv
// Self-checking bench for seq_recognizer_param: directed scenarios plus randomized stream against a queue model.
module tb_seq_recognizer_param;

`ifdef SEQ_RECOGNIZER_MATCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pattern_in = 4'b0000;
    logic       overlap = 1'b1;
    logic       valid = 1'b0;
    logic       x = 1'b0;
    logic       z, z_sat;
    logic [7:0] match_count;
    logic [1:0] cnt_sat;

    int n_chk = 0;
    int n_err = 0;

    // reference model: accepted bits since last flush, active pattern, match counts
    bit         mq[$];
    logic [3:0] mpat;
    int         mcnt;
    int         msat;

    seq_recognizer_param #(.PAT_W(4), .PAT_RST(4'b0000), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .load(load), .pattern_in(pattern_in),
        .overlap(overlap), .valid(valid), .x(x), .z(z), .match_count(match_count)
    );

    seq_recognizer_param #(.PAT_W(4), .PAT_RST(4'b0000), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .load(load), .pattern_in(pattern_in),
        .overlap(overlap), .valid(valid), .x(x), .z(z_sat), .match_count(cnt_sat)
    );

    always #5 clock = ~clock;

    function automatic int exp_cnt(input int c);
        return CNT_EN ? c : 0;
    endfunction

    task automatic cyc(input logic v, input logic xb, input logic ld, input logic ov);
        @(negedge clock);
        valid = v; x = xb; load = ld; overlap = ov;
        #1;
    endtask

    function automatic logic model_hit();
        int         n;
        logic [3:0] w;
        n = mq.size();
        if (!valid || load || n < 3) return 1'b0;
        w = {mq[n-3], mq[n-2], mq[n-1], x};
        return w == mpat;
    endfunction

    task automatic model_commit();
        logic h;
        if (load) begin
            mq.delete(); mpat = pattern_in; mcnt = 0; msat = 0;
        end else if (valid) begin
            h = model_hit();
            if (h) begin
                if (mcnt < 255) mcnt++;
                if (msat < 3) msat++;
            end
            if (h && !overlap) mq.delete();
            else begin
                mq.push_back(x);
                if (mq.size() > 3) void'(mq.pop_front());
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (z !== 1'b0) begin n_err++; $display("FAIL reset_z: got %b expected 0", z); end
        n_chk++; if (match_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", match_count); end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_zero_pattern();
        logic [4:0] e = 5'b00011;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 1);
            n_chk++; if (z !== e[4-i]) begin n_err++; $display("FAIL zero_pat_z bit%0d: got %b expected %b", i+1, z, e[4-i]); end
        end
        cyc(0, 0, 0, 1);
        n_chk++; if (match_count !== 8'(exp_cnt(2))) begin n_err++; $display("FAIL zero_pat_count: got %0d expected %0d", match_count, exp_cnt(2)); end
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001001;
        pattern_in = 4'b1011;
        cyc(1, 1, 1, 1);
        n_chk++; if (z !== 1'b0) begin n_err++; $display("FAIL ovl_load_z: got %b expected 0", z); end
        for (int i = 0; i < 7; i++) begin
            cyc(1, s[6-i], 0, 1);
            n_chk++; if (z !== e[6-i]) begin n_err++; $display("FAIL ovl_z bit%0d: got %b expected %b", i+1, z, e[6-i]); end
        end
        cyc(0, 0, 0, 1);
        n_chk++; if (match_count !== 8'(exp_cnt(2))) begin n_err++; $display("FAIL ovl_count: got %0d expected %0d", match_count, exp_cnt(2)); end
    endtask

    task automatic test_non_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001000;
        pattern_in = 4'b1011;
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1, s[6-i], 0, 0);
            n_chk++; if (z !== e[6-i]) begin n_err++; $display("FAIL novl_z bit%0d: got %b expected %b", i+1, z, e[6-i]); end
        end
        cyc(0, 0, 0, 0);
        n_chk++; if (match_count !== 8'(exp_cnt(1))) begin n_err++; $display("FAIL novl_count: got %0d expected %0d", match_count, exp_cnt(1)); end
    endtask

    task automatic test_gap();
        logic [2:0] s = 3'b101;
        pattern_in = 4'b1011;
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, s[2-i], 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, i[0], 0, 1);
            n_chk++; if (z !== 1'b0) begin n_err++; $display("FAIL gap_z cyc%0d: got %b expected 0", i, z); end
        end
        cyc(1, 1, 0, 1);
        n_chk++; if (z !== 1'b1) begin n_err++; $display("FAIL gap_final_z: got %b expected 1", z); end
    endtask

    task automatic test_reset_mid();
        logic [4:0] s = 5'b10000;
        logic [4:0] e = 5'b00001;
        logic [2:0] t = 3'b011;
        pattern_in = 4'b1011;
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, s[2-i] ^ (i == 0 ? 1'b0 : 1'b0) ^ (i == 2 ? 1'b1 : 1'b0), 0, 1);
        @(negedge clock); reset = 1'b0; valid = 1'b1; x = 1'b1; #1;
        n_chk++; if (z !== 1'b0) begin n_err++; $display("FAIL rst_mid_z: got %b expected 0", z); end
        n_chk++; if (match_count !== 8'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d expected 0", match_count); end
        @(negedge clock); reset = 1'b1;
        // pattern must now be 0000: 1,0,0,0,0 matches only on the last bit
        for (int i = 0; i < 5; i++) begin
            cyc(1, s[4-i], 0, 1);
            n_chk++; if (z !== e[4-i]) begin n_err++; $display("FAIL rst_pat_z bit%0d: got %b expected %b", i+1, z, e[4-i]); end
        end
        pattern_in = 4'b1011;
        cyc(1, 1, 1, 1);
        n_chk++; if (z !== 1'b0) begin n_err++; $display("FAIL load_valid_z: got %b expected 0", z); end
        for (int i = 0; i < 3; i++) begin
            cyc(1, t[2-i], 0, 1);
            n_chk++; if (z !== 1'b0) begin n_err++; $display("FAIL load_discard_z bit%0d: got %b expected 0", i+1, z); end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] e = 8'b00011111;
        pattern_in = 4'b1111;
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 1);
            n_chk++; if (z_sat !== e[7-i]) begin n_err++; $display("FAIL sat_z bit%0d: got %b expected %b", i+1, z_sat, e[7-i]); end
            if (i == 5) begin
                cyc(0, 0, 0, 1);
                n_chk++; if (cnt_sat !== 2'(exp_cnt(3))) begin n_err++; $display("FAIL sat_count6: got %0d expected %0d", cnt_sat, exp_cnt(3)); end
            end
        end
        cyc(0, 0, 0, 1);
        n_chk++; if (cnt_sat !== 2'(exp_cnt(3))) begin n_err++; $display("FAIL sat_hold: got %0d expected %0d", cnt_sat, exp_cnt(3)); end
        n_chk++; if (match_count !== 8'(exp_cnt(5))) begin n_err++; $display("FAIL sat_wide_count: got %0d expected %0d", match_count, exp_cnt(5)); end
    endtask

    task automatic test_random();
        logic v, xb, ld, ov, eh;
        pattern_in = 4'($urandom);
        cyc(1, 1'($urandom), 1, 1);
        @(posedge clock); model_commit();
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 59) == 0);
            ov = 1'($urandom);
            xb = 1'($urandom);
            if (ld) pattern_in = 4'($urandom);
            cyc(v, xb, ld, ov);
            eh = model_hit();
            n_chk++; if (z !== eh) begin n_err++; $display("FAIL rand_z cyc%0d: got %b expected %b", i, z, eh); end
            n_chk++; if (z_sat !== eh) begin n_err++; $display("FAIL rand_zsat cyc%0d: got %b expected %b", i, z_sat, eh); end
            n_chk++; if (match_count !== 8'(exp_cnt(mcnt))) begin n_err++; $display("FAIL rand_count cyc%0d: got %0d expected %0d", i, match_count, exp_cnt(mcnt)); end
            n_chk++; if (cnt_sat !== 2'(exp_cnt(msat))) begin n_err++; $display("FAIL rand_satcount cyc%0d: got %0d expected %0d", i, cnt_sat, exp_cnt(msat)); end
            @(posedge clock); model_commit();
        end
    endtask

    initial begin
        test_reset();
        test_zero_pattern();
        test_overlap();
        test_non_overlap();
        test_gap();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
